// File: rtl/morph_pass_scheduler.sv
// Multi-pass raster scheduler for a shared erode/dilate window unit.
// Each pass scans the frame plus LAG flush lines so the window pipeline drains.
//
//   state | meaning
//   IDLE  | waiting for start; configuration latched on acceptance
//   RUN   | raster scan of one pass (reads, then lagged writes)
//   NEXT  | one-cycle gap between passes; pass index advances
//   DONE  | one-cycle completion pulse, busy already low
module morph_pass_scheduler #(
   parameter int H_IMG_RES  = 640,
   parameter int V_IMG_RES  = 480,
   parameter int WIN_SIZE   = 5,
   parameter int MAX_PASSES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            pass_num,
   input  logic [MAX_PASSES-1:0] op_mask,
   output logic [10:0]           hpos,
   output logic [10:0]           vpos,
   output logic                  rd_en,
   output logic                  wr_en,
   output logic [10:0]           wr_hpos,
   output logic [10:0]           wr_vpos,
   output logic                  op_dilate,
   output logic [2:0]            pass_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int          LAG     = WIN_SIZE / 2 + 1;
   localparam logic [10:0] H_LAST  = 11'(H_IMG_RES - 1);
   localparam logic [10:0] S_LAST  = 11'(V_IMG_RES + LAG - 1);
   localparam logic [10:0] V_RES11 = 11'(V_IMG_RES);
   localparam logic [10:0] LAG11   = 11'(LAG);
   localparam logic [2:0]  MAX_P3  = 3'(MAX_PASSES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEXT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [10:0]           hpos_q, hpos_d;
   logic [10:0]           sline_q, sline_d;
   logic [2:0]            pass_idx_q, pass_idx_d;
   logic [2:0]            pass_cnt_q, pass_cnt_d;
   logic [MAX_PASSES-1:0] op_mask_q, op_mask_d;
   logic [2:0]            pass_clamped;
   logic [MAX_PASSES-1:0] mask_shifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hpos_q     <= '0;
         sline_q    <= '0;
         pass_idx_q <= '0;
         pass_cnt_q <= '0;
         op_mask_q  <= '0;
      end else begin
         state_q    <= state_d;
         hpos_q     <= hpos_d;
         sline_q    <= sline_d;
         pass_idx_q <= pass_idx_d;
         pass_cnt_q <= pass_cnt_d;
         op_mask_q  <= op_mask_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hpos_d       = hpos_q;
      sline_d      = sline_q;
      pass_idx_d   = pass_idx_q;
      pass_cnt_d   = pass_cnt_q;
      op_mask_d    = op_mask_q;
      pass_clamped = pass_num;
      if (pass_num == 3'd0)
         pass_clamped = 3'd1;
      else if (pass_num > MAX_P3)
         pass_clamped = MAX_P3;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               hpos_d     = '0;
               sline_d    = '0;
               pass_idx_d = '0;
               pass_cnt_d = pass_clamped;
               op_mask_d  = op_mask;
            end
         end
         S_RUN: begin
            if (hpos_q == H_LAST) begin
               hpos_d = '0;
               if (sline_q == S_LAST) begin
                  sline_d = '0;
                  state_d = ((pass_idx_q + 3'd1) < pass_cnt_q) ? S_NEXT : S_DONE;
               end else begin
                  sline_d = sline_q + 11'd1;
               end
            end else begin
               hpos_d = hpos_q + 11'd1;
            end
         end
         S_NEXT: begin
            state_d    = S_RUN;
            hpos_d     = '0;
            sline_d    = '0;
            pass_idx_d = pass_idx_q + 3'd1;
         end
         S_DONE: begin
            state_d    = S_IDLE;
            pass_idx_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mask_shifted = op_mask_q >> pass_idx_q;
   assign pass_idx     = pass_idx_q;

   always_comb begin
      hpos      = '0;
      vpos      = '0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      wr_hpos   = '0;
      wr_vpos   = '0;
      op_dilate = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_RUN: begin
            busy      = 1'b1;
            op_dilate = mask_shifted[0];
            hpos      = hpos_q;
            // Flush lines past the frame fold back onto the top rows as vpos.
            if (sline_q < V_RES11) begin
               vpos  = sline_q;
               rd_en = 1'b1;
            end else begin
               vpos  = sline_q - V_RES11;
            end
            if (sline_q >= LAG11) begin
               wr_en   = 1'b1;
               wr_hpos = hpos_q;
               wr_vpos = sline_q - LAG11;
            end
         end
         S_NEXT: begin
            busy      = 1'b1;
            op_dilate = mask_shifted[0];
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_morph_pass_scheduler.sv
// Bench for morph_pass_scheduler: per-cycle comparison against a raster model
// derived from pass/line/column arithmetic, table jobs, random jobs, mid-job reset.
module tb_morph_pass_scheduler;

   localparam int H   = 8;
   localparam int V   = 6;
   localparam int WIN = 3;
   localparam int MP  = 4;
   localparam int LAG = WIN / 2 + 1;
   localparam int L   = H * (V + LAG);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  pass_num = '0;
   logic [3:0]  op_mask = '0;
   logic [10:0] hpos, vpos, wr_hpos, wr_vpos;
   logic        rd_en, wr_en, op_dilate, busy, done;
   logic [2:0]  pass_idx;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [10:0] hpos;
      logic [10:0] vpos;
      logic [10:0] wrh;
      logic [10:0] wrv;
      logic        rd;
      logic        wr;
      logic        op;
      logic [2:0]  pidx;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct {
      logic [2:0] pn;
      logic [3:0] mk;
      int         exp_done;
   } vec_t;

   morph_pass_scheduler #(
      .H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(WIN), .MAX_PASSES(MP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pass_num(pass_num), .op_mask(op_mask),
      .hpos(hpos), .vpos(vpos), .rd_en(rd_en), .wr_en(wr_en),
      .wr_hpos(wr_hpos), .wr_vpos(wr_vpos), .op_dilate(op_dilate),
      .pass_idx(pass_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic obs_t get_obs();
      obs_t o;
      o.hpos = hpos; o.vpos = vpos; o.wrh = wr_hpos; o.wrv = wr_vpos;
      o.rd = rd_en; o.wr = wr_en; o.op = op_dilate; o.pidx = pass_idx;
      o.busy = busy; o.done = done;
      return o;
   endfunction

   // Expected outputs c cycles after the start edge for an n-pass job.
   function automatic obs_t model(int c, int n, logic [3:0] mk);
      obs_t e;
      int seg, p, t, line;
      e = '0;
      seg = L + 1;
      if (c == n * seg) begin
         e.done = 1'b1;
      end else if (c >= 1 && c < n * seg) begin
         p = (c - 1) / seg;
         t = (c - 1) % seg;
         e.busy = 1'b1;
         e.pidx = 3'(p);
         e.op   = 1'(mk >> p);
         if (t < L) begin
            line   = t / H;
            e.hpos = 11'(t % H);
            if (line < V) begin
               e.rd   = 1'b1;
               e.vpos = 11'(line);
            end else begin
               e.vpos = 11'(line - V);
            end
            if (line >= LAG) begin
               e.wr  = 1'b1;
               e.wrh = e.hpos;
               e.wrv = 11'(line - LAG);
            end
         end
      end
      return e;
   endfunction

   task automatic cmp_obs(input string name, input int c, input obs_t act, input obs_t exp_v,
                          input obs_t m);
      total++;
      if ((act & m) !== (exp_v & m)) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act & m, exp_v & m);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
      end
   endtask

   task automatic run_job(input logic [2:0] pn, input logic [3:0] mk, input int exp_done,
                          input bit noise);
      int n, rdc, wrc, first_wr, done_at, last;
      obs_t o, e, m;
      n = (pn == 3'd0) ? 1 : ((int'(pn) > MP) ? MP : int'(pn));
      rdc = 0; wrc = 0; first_wr = -1; done_at = -1;
      last = n * (L + 1) + 1;
      m = '1;
      cmp_obs("idle_before", 0, get_obs(), '0, m);
      start = 1'b1; pass_num = pn; op_mask = mk;
      @(posedge clk); #1;
      for (int c = 1; c <= last; c++) begin
         start = (noise && c < last) ? 1'($urandom) : 1'b0;
         if (noise) begin
            pass_num = 3'($urandom);
            op_mask  = 4'($urandom);
         end
         o = get_obs();
         e = model(c, n, mk);
         m = '1;
         if (e.done) m.pidx = '0;
         cmp_obs("cycle", c, o, e, m);
         if (c <= L) begin
            rdc += int'(o.rd);
            wrc += int'(o.wr);
            if (o.wr && first_wr < 0) begin
               first_wr = c - 1;
               chk("first_wr_pos", int'(o.wrh) + int'(o.wrv), 0);
            end
         end
         if (o.done && done_at < 0) done_at = c;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("rd_count", rdc, H * V);
      chk("wr_count", wrc, H * V);
      chk("first_wr_cycle", first_wr, LAG * H);
      chk("done_cycle", done_at, exp_done);
   endtask

   vec_t vecs[6];

   initial begin
      obs_t o;
      int budget, seen_done;

      vecs[0] = '{3'd1, 4'b0000, 65};
      vecs[1] = '{3'd3, 4'b0101, 195};
      vecs[2] = '{3'd0, 4'b1111, 65};
      vecs[3] = '{3'd7, 4'b1010, 260};
      vecs[4] = '{3'd4, 4'b0110, 260};
      vecs[5] = '{3'd2, 4'b0011, 130};

      #1;
      cmp_obs("reset_state", 0, get_obs(), '0, '1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      cmp_obs("reset_hold", 0, get_obs(), '0, '1);
      rst = 1'b0;

      foreach (vecs[i]) run_job(vecs[i].pn, vecs[i].mk, vecs[i].exp_done, 1'b0);
      run_job(3'd7, 4'b1001, 260, 1'b1);

      for (int r = 0; r < 4; r++) begin
         logic [2:0] pn;
         int n;
         pn = 3'($urandom_range(0, 7));
         n = (pn == 3'd0) ? 1 : ((int'(pn) > MP) ? MP : int'(pn));
         run_job(pn, 4'($urandom), n * (L + 1), 1'b1);
      end

      // Mid-job reset during the second pass: outputs clear at once, no done.
      start = 1'b1; pass_num = 3'd3; op_mask = 4'b0101;
      @(posedge clk); #1;
      start = 1'b0;
      budget = 0;
      while (!(pass_idx == 3'd1 && hpos == 11'd5 && vpos == 11'd2) && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("reach_pass2", int'(budget < 300), 1);
      #2 rst = 1'b1;
      #1;
      cmp_obs("rst_async", 0, get_obs(), '0, '1);
      seen_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         o = get_obs();
         if (o.done) seen_done = 1;
      end
      chk("no_done_after_abort", seen_done, 0);
      cmp_obs("rst_held", 0, get_obs(), '0, '1);
      rst = 1'b0;
      run_job(3'd3, 4'b0101, 195, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/morph_pass_scheduler.md
MORPH_PASS_SCHEDULER -- requirements
Module: morph_pass_scheduler

Interface
REQ-001 SHALL have parameter H_IMG_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_IMG_RES, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter WIN_SIZE, default 5, meaning odd window size of the shared morphology unit; LAG = WIN_SIZE/2+1 lines.
REQ-004 SHALL have parameter MAX_PASSES, default 4, meaning maximum number of passes per job.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  sole clock, rising edge.
REQ-006 SHALL have rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have start  input  1  job request, sampled only in IDLE.
REQ-008 SHALL have pass_num  input  3  passes requested; 0 is treated as 1; values above MAX_PASSES are clamped to MAX_PASSES.
REQ-009 SHALL have op_mask  input  MAX_PASSES  bit k=1 selects dilate, 0 selects erode, for pass k.
REQ-010 SHALL have hpos  output  11  column driven to the morphology unit and source buffer.
REQ-011 SHALL have vpos  output  11  line driven to the morphology unit and source buffer.
REQ-012 SHALL have rd_en  output  1  source pixel at (hpos,vpos) is valid input this cycle.
REQ-013 SHALL have wr_en  output  1  morphology output this cycle is a valid result pixel.
REQ-014 SHALL have wr_hpos, wr_vpos  output  11 each  destination coordinate of the result pixel.
REQ-015 SHALL have op_dilate  output  1  operation select for the current pass.
REQ-016 SHALL have pass_idx  output  3  index of the current pass, 0-based.
REQ-017 SHALL have busy  output  1  high from acceptance of start until done.
REQ-018 SHALL have done  output  1  single-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, RUN, NEXT, DONE.
REQ-020 SHALL, in IDLE with start=1, latch pass_num (clamped) and op_mask, enter RUN next cycle with hpos=0, scan line=0, pass_idx=0, busy=1.
REQ-021 SHALL keep an internal scan line counter sline running 0..V_IMG_RES+LAG-1; hpos counts 0..H_IMG_RES-1 every cycle in RUN, sline increments when hpos wraps.
REQ-022 SHALL drive vpos = sline when sline < V_IMG_RES, else sline - V_IMG_RES (wrap-around flush lines).
REQ-023 SHALL assert rd_en in RUN only when sline < V_IMG_RES.
REQ-024 SHALL assert wr_en in RUN only when sline >= LAG, with wr_vpos = sline - LAG and wr_hpos = hpos, same cycle (combinational from state/counters).
REQ-025 SHALL spend exactly H_IMG_RES*(V_IMG_RES+LAG) cycles in RUN per pass; wr_en high exactly H_IMG_RES*V_IMG_RES of them.
REQ-026 SHALL, on the last RUN cycle of a pass, go to NEXT if pass_idx+1 < latched pass count, else DONE.
REQ-027 SHALL spend exactly one cycle in NEXT (rd_en=wr_en=0, counters zeroed), increment pass_idx, then return to RUN.
REQ-028 SHALL drive op_dilate = latched op_mask[pass_idx] in RUN and NEXT; 0 in IDLE.
REQ-029 SHALL, in DONE, pulse done=1 for one cycle with busy=0, then return to IDLE; start in DONE is ignored.
REQ-030 SHALL ignore start while busy=1; no restart, no queuing.
REQ-031 SHALL hold hpos, vpos, wr_hpos, wr_vpos at 0 and rd_en, wr_en at 0 outside RUN.
REQ-032 SHALL use 11-bit unsigned counters; no intermediate expression exceeds 12 bits.

Reset
REQ-033 SHALL, while rst=1, force IDLE, all outputs 0, pass_idx=0, latched configuration 0, asynchronously.
REQ-034 SHALL abort any job when rst asserts mid-pass; no done pulse is issued for the aborted job.
REQ-035 SHALL accept start on the first rising clk edge after rst deasserts.

Verification (H_IMG_RES=8, V_IMG_RES=6, WIN_SIZE=3, LAG=2, MAX_PASSES=4)
REQ-036 SHALL cover: start=1, pass_num=1 -> 64 RUN cycles, rd_en count 48, wr_en count 48, first wr_en at cycle 16 with (0,0), done on cycle 65 after start.
REQ-037 SHALL cover: pass_num=3, op_mask=4'b0101 -> op_dilate 1,0,1 per pass, one NEXT cycle each, done after 3*64+2+1 cycles.
REQ-038 SHALL cover: sline=6,7 -> vpos=0,1 with rd_en=0, wr_vpos=4,5 with wr_en=1.
REQ-039 SHALL cover: start pulsed during RUN -> no effect; pass_num=0 -> one pass; pass_num=7 -> four passes.
REQ-040 SHALL cover: rst asserted mid pass 2 -> all outputs 0 immediately, no done; new start afterwards runs a full job.
